noise_estimation_frame_stats: RTL and testbench

- Second-generation frame noise estimator. Consumes a raster of fixed-size pixel blocks on one channel and computes each block's variance in a single pass using running sum and sum-of-squares, with no pixel shift register.
- Reduces the per-block variances over a runtime-programmable number of blocks to one frame noise figure.
- Reduction mode is runtime-selectable: true mean with sequential division by blocks_per_frame, or minimum block variance.
- Sits between the block scanner and the denoise filter coefficient logic.

---
 rtl/noise_estimation_frame_stats.sv | 247 ++++++++++++++++++++++++
 tb/tb_noise_estimation_frame_stats.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_estimation_frame_stats.sv
// Frame noise estimator: single-pass per-block variance from running sum and
// sum-of-squares, reduced over a programmable number of blocks to either the
// floored mean of the block variances (sequential restoring divide) or the
// minimum block variance.
// BLOCK_SIZE must be a power of two and at least 2.
module noise_estimation_frame_stats #(
    parameter int DATA_WIDTH    = 8,
    parameter int BLOCK_SIZE    = 64,
    parameter int BLK_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_of_frame,
    input  logic                      data_valid,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic [BLK_CNT_WIDTH-1:0]  blocks_per_frame,
    input  logic                      mode,
    output logic [2*DATA_WIDTH-1:0]   block_var,
    output logic                      block_var_valid,
    output logic [2*DATA_WIDTH-1:0]   estimated_noise,
    output logic                      estimated_noise_ready,
    output logic                      busy,
    output logic                      overrun
);

    localparam int W   = DATA_WIDTH;
    localparam int L   = $clog2(BLOCK_SIZE);
    localparam int B   = BLK_CNT_WIDTH;
    localparam int SW  = W + L;          // running sum width
    localparam int QW  = 2 * W + L;      // running sum-of-squares width
    localparam int VW  = 2 * W;          // variance width
    localparam int AW  = 2 * W + B;      // frame accumulator / dividend width
    localparam int PW  = 2 * W + 2 * L;  // width of N*Q and S*S
    localparam int DCW = $clog2(AW + 1); // divide step counter width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state, next_state;

    // Per-block accumulation state
    logic [SW-1:0]  sum_s;
    logic [QW-1:0]  sum_q;
    logic [L-1:0]   pix_cnt;

    // Per-frame control state
    logic [B-1:0]   blocks_lat;
    logic           mode_lat;
    logic [B-1:0]   blk_cnt;
    logic           fold_pending;   // block_var holds a variance of the live frame
    logic           fold_first;     // ... and it is the frame's first block
    logic           frame_end;      // ... and it is the frame's last block

    // Frame reduction and divider state
    logic [AW-1:0]  acc;
    logic [VW-1:0]  min_var;
    logic [AW-1:0]  quot;
    logic [B-1:0]   rem;
    logic [DCW-1:0] div_cnt;

    // Combinational helpers
    logic           accept_first;
    logic           accept;
    logic           drop;
    logic [L-1:0]   pix_cnt_eff;
    logic [SW-1:0]  s_eff, s_next;
    logic [QW-1:0]  q_eff, q_next;
    logic [VW-1:0]  pix_ext, pix_sq;
    logic [PW-1:0]  q_scaled, s_ext, s_sq, var_diff;
    logic [VW-1:0]  var_calc;
    logic [B-1:0]   blocks_new, blocks_eff, blk_eff;
    logic           last_pix, last_blk;
    logic           fold;
    logic [AW-1:0]  acc_sum;
    logic [VW-1:0]  min_next;
    logic [B:0]     div_shift, div_diff;
    logic           div_take;
    logic           div_last;
    logic           div_load;

    // Input qualification and single-pass variance arithmetic
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        accept_first = data_valid && start_of_frame && (state == IDLE || state == ACCUM);
        accept       = accept_first || (data_valid && state == ACCUM && !frame_end);
        drop         = data_valid && (state == DIVIDE || state == DONE);

        // A start_of_frame pixel restarts everything from zero, aborting any frame in flight.
        pix_cnt_eff = accept_first ? '0 : pix_cnt;
        s_eff       = accept_first ? '0 : sum_s;
        q_eff       = accept_first ? '0 : sum_q;
        blk_eff     = accept_first ? '0 : blk_cnt;
        blocks_new  = (blocks_per_frame == '0) ? B'(1) : blocks_per_frame;
        blocks_eff  = accept_first ? blocks_new : blocks_lat;

        pix_ext  = {{W{1'b0}}, data_in};
        pix_sq   = pix_ext * pix_ext;
        s_next   = s_eff + {{L{1'b0}}, data_in};
        q_next   = q_eff + {{L{1'b0}}, pix_sq};

        // var = (N*Q - S*S) / N^2, exact and never negative since N*Q >= S*S.
        q_scaled = {q_next, {L{1'b0}}};
        s_ext    = {{(W + L){1'b0}}, s_next};
        s_sq     = s_ext * s_ext;
        var_diff = q_scaled - s_sq;
        var_calc = VW'(var_diff >> (2 * L));

        last_pix = accept && (pix_cnt_eff == L'(BLOCK_SIZE - 1));
        last_blk = (blk_eff == blocks_eff - B'(1));
    end

    // Frame reduction and divider step arithmetic
    always_comb begin
        fold     = fold_pending && !accept_first;
        acc_sum  = acc + {{B{1'b0}}, block_var};
        min_next = (fold_first || block_var < min_var) ? block_var : min_var;

        div_shift = {rem, quot[AW-1]};
        div_diff  = div_shift - {1'b0, blocks_lat};
        div_take  = !div_diff[B];
        div_last  = (div_cnt == DCW'(AW - 1));
        div_load  = (state == ACCUM) && (next_state == DIVIDE);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (accept_first) next_state = ACCUM;
            ACCUM: begin
                if (accept_first)   next_state = ACCUM;
                else if (frame_end) next_state = mode_lat ? DONE : DIVIDE;
            end
            DIVIDE: if (div_last)     next_state = DONE;
            DONE:                     next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    // Moore outputs of the FSM
    always_comb begin
        busy = (state == DIVIDE) || (state == DONE);
    end

    // Block accumulators and registered block variance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_s           <= '0;
            sum_q           <= '0;
            pix_cnt         <= '0;
            block_var       <= '0;
            block_var_valid <= 1'b0;
        end else begin
            block_var_valid <= last_pix;
            if (last_pix) begin
                block_var <= var_calc;
                sum_s     <= '0;
                sum_q     <= '0;
                pix_cnt   <= '0;
            end else if (accept) begin
                sum_s   <= s_next;
                sum_q   <= q_next;
                pix_cnt <= pix_cnt_eff + L'(1);
            end
        end
    end

    // Frame parameters and block counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocks_lat   <= '0;
            mode_lat     <= 1'b0;
            blk_cnt      <= '0;
            fold_pending <= 1'b0;
            fold_first   <= 1'b0;
            frame_end    <= 1'b0;
        end else begin
            fold_pending <= last_pix;
            frame_end    <= last_pix && last_blk;
            if (last_pix) fold_first <= (blk_eff == '0);
            if (accept_first) begin
                blocks_lat <= blocks_new;
                mode_lat   <= mode;
            end
            if (accept) begin
                if (last_pix) blk_cnt <= last_blk ? '0 : blk_eff + B'(1);
                else          blk_cnt <= blk_eff;
            end
        end
    end

    // Frame reduction: running sum of variances or running minimum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            min_var <= '0;
        end else if (accept_first) begin
            acc     <= '0;
            min_var <= '0;
        end else if (fold) begin
            if (mode_lat) min_var <= min_next;
            else          acc     <= acc_sum;
        end
    end

    // Restoring divider: one quotient bit per cycle, MSB first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot    <= '0;
            rem     <= '0;
            div_cnt <= '0;
        end else if (div_load) begin
            quot    <= acc_sum;
            rem     <= '0;
            div_cnt <= '0;
        end else if (state == DIVIDE) begin
            quot    <= {quot[AW-2:0], div_take};
            rem     <= div_take ? div_diff[B-1:0] : div_shift[B-1:0];
            div_cnt <= div_cnt + DCW'(1);
        end
    end

    // Result register, ready pulse and overrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estimated_noise       <= '0;
            estimated_noise_ready <= 1'b0;
            overrun               <= 1'b0;
        end else begin
            estimated_noise_ready <= (state == DONE);
            overrun               <= drop;
            if (state == DONE) estimated_noise <= mode_lat ? min_var : quot[VW-1:0];
        end
    end

endmodule

// File: tb/tb_noise_estimation_frame_stats.sv
// Directed bench for noise_estimation_frame_stats with 4-pixel blocks, 8-bit
// pixels and a 16-bit block count; expected values are hand-computed.
module tb_noise_estimation_frame_stats;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_of_frame;
    logic        data_valid;
    logic [7:0]  data_in;
    logic [15:0] blocks_per_frame;
    logic        mode;
    logic [15:0] block_var;
    logic        block_var_valid;
    logic [15:0] estimated_noise;
    logic        estimated_noise_ready;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int ready_count = 0;
    int lat, busy_n, rc;

    noise_estimation_frame_stats #(
        .DATA_WIDTH(8),
        .BLOCK_SIZE(4),
        .BLK_CNT_WIDTH(16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start_of_frame        (start_of_frame),
        .data_valid            (data_valid),
        .data_in               (data_in),
        .blocks_per_frame      (blocks_per_frame),
        .mode                  (mode),
        .block_var             (block_var),
        .block_var_valid       (block_var_valid),
        .estimated_noise       (estimated_noise),
        .estimated_noise_ready (estimated_noise_ready),
        .busy                  (busy),
        .overrun               (overrun)
    );

    always #5 clk = ~clk;

    // Count every ready pulse, sampled away from the active edge
    always @(negedge clk) if (estimated_noise_ready === 1'b1) ready_count++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pixel(input logic s, input logic [7:0] x);
        @(negedge clk);
        start_of_frame = s;
        data_valid     = 1'b1;
        data_in        = x;
        @(posedge clk);
        #1;
        data_valid     = 1'b0;
        start_of_frame = 1'b0;
    endtask

    task automatic block4(input logic s, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        pixel(s, a);
        pixel(1'b0, b);
        pixel(1'b0, c);
        pixel(1'b0, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_frame(input logic [15:0] bpf, input logic m);
        blocks_per_frame = bpf;
        mode             = m;
    endtask

    // Cycles from now until ready is seen (-1 on timeout), and busy samples before it
    task automatic wait_ready(input int limit, output int l, output int bn);
        l  = -1;
        bn = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (estimated_noise_ready === 1'b1) begin
                l = i;
                break;
            end
            if (busy === 1'b1) bn++;
        end
    endtask

    initial begin
        rst              = 1'b1;
        start_of_frame   = 1'b0;
        data_valid       = 1'b0;
        data_in          = '0;
        blocks_per_frame = '0;
        mode             = 1'b0;

        // Reset state
        idle(3);
        check("rst_block_var", block_var, 0);
        check("rst_block_var_valid", block_var_valid, 0);
        check("rst_noise", estimated_noise, 0);
        check("rst_ready", estimated_noise_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b0;

        // Flat block, min mode: variance 0, ready 2 cycles after last pixel
        set_frame(16'd1, 1'b1);
        block4(1'b1, 8'd100, 8'd100, 8'd100, 8'd100);
        check("t1_valid", block_var_valid, 1);
        check("t1_var", block_var, 0);
        wait_ready(10, lat, busy_n);
        check("t1_latency", lat, 2);
        check("t1_noise", estimated_noise, 0);

        // Two back-to-back blocks, min mode
        set_frame(16'd2, 1'b1);
        pixel(1'b1, 8'd0);
        pixel(1'b0, 8'd0);
        pixel(1'b0, 8'd255);
        check("t2_valid_early", block_var_valid, 0);
        pixel(1'b0, 8'd255);
        check("t2_valid_a", block_var_valid, 1);
        check("t2_var_a", block_var, 16256);
        pixel(1'b0, 8'd10);
        check("t2_valid_pulse", block_var_valid, 0);
        pixel(1'b0, 8'd20);
        pixel(1'b0, 8'd30);
        pixel(1'b0, 8'd40);
        check("t2_valid_b", block_var_valid, 1);
        check("t2_var_b", block_var, 125);
        wait_ready(10, lat, busy_n);
        check("t2_latency", lat, 2);
        check("t2_noise", estimated_noise, 125);

        // Three blocks, mean mode: (0+125+16256)/3 = 5460
        set_frame(16'd3, 1'b0);
        block4(1'b1, 8'd100, 8'd100, 8'd100, 8'd100);
        block4(1'b0, 8'd10, 8'd20, 8'd30, 8'd40);
        block4(1'b0, 8'd0, 8'd0, 8'd255, 8'd255);
        check("t3_var", block_var, 16256);
        wait_ready(60, lat, busy_n);
        check("t3_latency", lat, 34);
        check("t3_busy_cycles", busy_n, 33);
        check("t3_noise", estimated_noise, 5460);
        check("t3_busy_after", busy, 0);

        // Same frame, min mode
        set_frame(16'd3, 1'b1);
        block4(1'b1, 8'd100, 8'd100, 8'd100, 8'd100);
        block4(1'b0, 8'd10, 8'd20, 8'd30, 8'd40);
        block4(1'b0, 8'd0, 8'd0, 8'd255, 8'd255);
        wait_ready(10, lat, busy_n);
        check("t4_latency", lat, 2);
        check("t4_noise", estimated_noise, 0);

        // blocks_per_frame=0 acts as 1; pixels during DIVIDE are dropped
        set_frame(16'd0, 1'b0);
        block4(1'b1, 8'd0, 8'd0, 8'd255, 8'd255);
        idle(1);
        check("t5_busy", busy, 1);
        pixel(1'b1, 8'd55);
        check("t5_overrun_a", overrun, 1);
        pixel(1'b0, 8'd77);
        check("t5_overrun_b", overrun, 1);
        idle(1);
        check("t5_overrun_clear", overrun, 0);
        wait_ready(60, lat, busy_n);
        check("t5_latency", lat, 30);
        check("t5_noise", estimated_noise, 16256);

        // Abort mid-block, then a complete 2-block mean frame of {125,125}
        set_frame(16'd1, 1'b1);
        pixel(1'b1, 8'd255);
        pixel(1'b0, 8'd0);
        rc = ready_count;
        set_frame(16'd2, 1'b0);
        block4(1'b1, 8'd10, 8'd20, 8'd30, 8'd40);
        check("t6_var_first", block_var, 125);
        block4(1'b0, 8'd10, 8'd20, 8'd30, 8'd40);
        wait_ready(60, lat, busy_n);
        check("t6_latency", lat, 34);
        check("t6_noise", estimated_noise, 125);
        idle(1);
        check("t6_ready_count", ready_count, rc + 1);

        // Asynchronous reset mid-ACCUM
        set_frame(16'd1, 1'b1);
        pixel(1'b1, 8'd9);
        pixel(1'b0, 8'd9);
        #2;
        rst = 1'b1;
        #1;
        check("t7_noise", estimated_noise, 0);
        check("t7_block_var", block_var, 0);
        check("t7_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        rc = ready_count;
        pixel(1'b0, 8'd9);
        pixel(1'b0, 8'd9);
        idle(5);
        check("t7_no_ready", ready_count, rc);
        check("t7_no_valid", block_var_valid, 0);

        // Asynchronous reset mid-DIVIDE
        set_frame(16'd1, 1'b0);
        block4(1'b1, 8'd0, 8'd0, 8'd255, 8'd255);
        idle(5);
        check("t8_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t8_busy", busy, 0);
        check("t8_block_var", block_var, 0);
        check("t8_noise", estimated_noise, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(40);
        check("t8_no_ready", ready_count, rc);

        // Recovery frame after resets
        set_frame(16'd1, 1'b1);
        block4(1'b1, 8'd10, 8'd20, 8'd30, 8'd40);
        wait_ready(10, lat, busy_n);
        check("t9_latency", lat, 2);
        check("t9_noise", estimated_noise, 125);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
